// File: rtl/core_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : core_run_controller
// Purpose  : Run sequencer for the 9-bit, 4-register core. Clears the
//            register file, releases the core, detects halt (halt PC or a
//            run of all-zero instructions), enforces a cycle budget and
//            reports done, timeout and cycle/instruction counts.
// Revision : 1.0 - initial release
// ============================================================================
module core_run_controller #(
    parameter int                PC_W       = 8,
    parameter int                CYCLE_W    = 16,
    parameter int unsigned       MAX_CYCLES = 16'hFFFF,
    parameter logic [PC_W-1:0]   HALT_PC    = 8'hFF,
    parameter int                HALT_ZEROS = 1,
    parameter int                NUM_REGS   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [PC_W-1:0]    pc,
    input  logic [8:0]         mach_code,
    output logic               core_rst,
    output logic               core_en,
    output logic               clr_wen,
    output logic [1:0]         clr_addr,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycle_count,
    output logic [CYCLE_W-1:0] instr_count
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_CLEAR = 2'd1;
    localparam logic [1:0] c_RUN   = 2'd2;
    localparam logic [1:0] c_DONE  = 2'd3;

    localparam logic [1:0]         c_LAST_ADDR  = 2'(NUM_REGS - 1);
    localparam logic [2:0]         c_ZR_HALT    = 3'(HALT_ZEROS - 1);
    localparam logic [CYCLE_W-1:0] c_LAST_CYCLE = CYCLE_W'(MAX_CYCLES - 1);

    logic [1:0]         r_state;
    logic [1:0]         r_clr_addr;
    logic [2:0]         r_zero_run;
    logic               r_timeout;
    logic [CYCLE_W-1:0] r_cycle_count;
    logic [CYCLE_W-1:0] r_instr_count;

    logic w_in_run;
    logic w_halt_now;
    logic w_core_en;
    logic w_last_budget;

    // Halt detection and commit enable; the halting instruction never commits
    always_comb begin
        w_in_run      = (r_state == c_RUN);
        w_halt_now    = w_in_run &&
                        ((pc == HALT_PC) ||
                         ((mach_code == 9'd0) && (r_zero_run == c_ZR_HALT)));
        w_core_en     = w_in_run && !w_halt_now;
        w_last_budget = (r_cycle_count == c_LAST_CYCLE);
    end

    // Main sequencer: state, clear address, counters and timeout flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= c_IDLE;
            r_clr_addr    <= 2'd0;
            r_timeout     <= 1'b0;
            r_cycle_count <= '0;
            r_instr_count <= '0;
        end else begin
            case (r_state)
                c_IDLE, c_DONE: begin
                    // A new run starts from a clean slate on the same edge
                    if (start) begin
                        r_state       <= c_CLEAR;
                        r_clr_addr    <= 2'd0;
                        r_timeout     <= 1'b0;
                        r_cycle_count <= '0;
                        r_instr_count <= '0;
                    end
                end
                c_CLEAR: begin
                    if (r_clr_addr == c_LAST_ADDR) begin
                        r_state    <= c_RUN;
                        r_clr_addr <= 2'd0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 2'd1;
                    end
                end
                c_RUN: begin
                    if (r_cycle_count != '1) begin
                        r_cycle_count <= r_cycle_count + 1'b1;
                    end
                    if (w_core_en && (r_instr_count != '1)) begin
                        r_instr_count <= r_instr_count + 1'b1;
                    end
                    // Halt wins over budget expiry in the same cycle
                    if (w_halt_now) begin
                        r_state   <= c_DONE;
                        r_timeout <= 1'b0;
                    end else if (w_last_budget) begin
                        r_state   <= c_DONE;
                        r_timeout <= 1'b1;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Consecutive all-zero instruction counter, only live while running
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_zero_run <= 3'd0;
        end else if (!w_in_run || (mach_code != 9'd0)) begin
            r_zero_run <= 3'd0;
        end else if (r_zero_run != 3'd7) begin
            r_zero_run <= r_zero_run + 3'd1;
        end
    end

    assign core_rst    = (r_state == c_IDLE) || (r_state == c_CLEAR);
    assign core_en     = w_core_en;
    assign clr_wen     = (r_state == c_CLEAR);
    assign clr_addr    = r_clr_addr;
    assign done        = (r_state == c_DONE);
    assign timeout     = r_timeout;
    assign cycle_count = r_cycle_count;
    assign instr_count = r_instr_count;

endmodule
`default_nettype wire

// File: tb/tb_core_run_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_core_run_controller
// Purpose  : Self-checking bench for core_run_controller. Programs are
//            per-RUN-cycle (pc, mach_code) tables; a run-level model derives
//            the expected end cycle, counts, timeout and per-cycle enable.
// Revision : 1.0 - initial release
// ============================================================================
module tb_core_run_controller;

    localparam int          T_MAX     = 20;
    localparam int          T_HZ      = 2;
    localparam logic [7:0]  T_HALT_PC = 8'hFF;
    localparam int          BUDGET    = 40;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  pc;
    logic [8:0]  mach_code;
    logic        core_rst;
    logic        core_en;
    logic        clr_wen;
    logic [1:0]  clr_addr;
    logic        done;
    logic        timeout;
    logic [15:0] cycle_count;
    logic [15:0] instr_count;

    int n_checks = 0;
    int n_errors = 0;

    // Program table and observations
    logic [7:0] prog_pc [0:63];
    logic [8:0] prog_mc [0:63];
    logic       obs_en  [0:63];
    logic       obs_rst [0:63];
    int         obs_cycles;
    logic       obs_cw [0:3];
    logic [1:0] obs_ca [0:3];
    logic       obs_cr [0:3];
    logic       obs_done0, obs_to0;
    logic [15:0] obs_cc0, obs_ic0;

    // Model results
    int   exp_cycles;
    int   exp_instr;
    logic exp_timeout;

    core_run_controller #(
        .PC_W       (8),
        .CYCLE_W    (16),
        .MAX_CYCLES (T_MAX),
        .HALT_PC    (T_HALT_PC),
        .HALT_ZEROS (T_HZ),
        .NUM_REGS   (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .pc          (pc),
        .mach_code   (mach_code),
        .core_rst    (core_rst),
        .core_en     (core_en),
        .clr_wen     (clr_wen),
        .clr_addr    (clr_addr),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    // Run-level reference: walk the program until halt or budget is spent
    function automatic void model_run();
        int zr = 0;
        exp_cycles  = T_MAX;
        exp_instr   = T_MAX;
        exp_timeout = 1'b1;
        for (int i = 0; i < T_MAX; i++) begin
            zr = (prog_mc[i] == 9'd0) ? zr + 1 : 0;
            if (prog_pc[i] == T_HALT_PC || zr >= T_HZ) begin
                exp_cycles  = i + 1;
                exp_instr   = i;
                exp_timeout = 1'b0;
                return;
            end
        end
    endfunction

    // Harmless program: counting PC, nonzero instructions
    task automatic fill_default();
        for (int i = 0; i < 64; i++) begin
            prog_pc[i] = 8'(i % 16);
            prog_mc[i] = 9'h100 | 9'(i);
        end
    endtask

    // Start pulse (optionally held through CLEAR); records the clear cycles
    task automatic begin_run(input bit hold_start);
        start = 1'b1;
        @(posedge clk); #1;
        if (!hold_start) start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            obs_cw[k] = clr_wen;
            obs_ca[k] = clr_addr;
            obs_cr[k] = core_rst;
            if (k == 0) begin
                obs_done0 = done;
                obs_to0   = timeout;
                obs_cc0   = cycle_count;
                obs_ic0   = instr_count;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
    endtask

    // Feed the program one entry per RUN cycle until done rises (bounded)
    task automatic drive_program(input int start_at);
        obs_cycles = -1;
        for (int i = 0; i < 64; i++) begin
            obs_en[i]  = 1'bx;
            obs_rst[i] = 1'bx;
        end
        for (int i = 0; i < BUDGET; i++) begin
            pc        = prog_pc[i];
            mach_code = prog_mc[i];
            start     = (i == start_at);
            @(negedge clk);
            obs_en[i]  = core_en;
            obs_rst[i] = core_rst;
            @(posedge clk); #1;
            start = 1'b0;
            if (done === 1'b1) begin
                obs_cycles = i + 1;
                break;
            end
        end
        if (obs_cycles < 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL run_bound: done not seen within %0d cycles", BUDGET);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; pc = 8'd0; mach_code = 9'h1;
        #2 reset = 1'b0;
        #2;
        n_checks++;
        if ({core_rst, core_en, clr_wen, clr_addr, done, timeout} !== 7'b1000000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got rst/en/wen/addr/done/to=%b%b%b%b%b%b want 1000000",
                     core_rst, core_en, clr_wen, clr_addr, done, timeout);
        end
        n_checks++;
        if (cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            n_errors++;
            $display("FAIL reset_counts: got cc=%0d ic=%0d want 0 0", cycle_count, instr_count);
        end
        @(negedge clk); reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        n_checks++;
        if (core_rst !== 1'b1 || clr_wen !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle: got rst=%b wen=%b done=%b want 1 0 0", core_rst, clr_wen, done);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_clear_sequence();
        fill_default();
        begin_run(1'b0);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_cw[k] !== 1'b1 || obs_ca[k] !== 2'(k) || obs_cr[k] !== 1'b1) begin
                n_errors++;
                $display("FAIL clear_cycle%0d: got wen=%b addr=%0d rst=%b want 1 %0d 1",
                         k, obs_cw[k], obs_ca[k], obs_cr[k], k);
            end
        end
        prog_pc[5] = T_HALT_PC;
        drive_program(-1);
        n_checks++;
        if (obs_rst[0] !== 1'b0 || obs_en[0] !== 1'b1) begin
            n_errors++;
            $display("FAIL first_run_cycle: got rst=%b en=%b want 0 1", obs_rst[0], obs_en[0]);
        end
    endtask

    task automatic test_pc_halt();
        fill_default();
        for (int i = 0; i < 10; i++) prog_pc[i] = 8'(i);
        prog_pc[10] = T_HALT_PC;
        model_run();
        begin_run(1'b0);
        drive_program(-1);
        n_checks++;
        if (obs_cycles !== exp_cycles || cycle_count !== 16'(exp_cycles) ||
            instr_count !== 16'(exp_instr) || timeout !== exp_timeout) begin
            n_errors++;
            $display("FAIL pc_halt: got end=%0d cc=%0d ic=%0d to=%b want %0d %0d %0d %b",
                     obs_cycles, cycle_count, instr_count, timeout,
                     exp_cycles, exp_cycles, exp_instr, exp_timeout);
        end
        n_checks++;
        if (obs_en[10] !== 1'b0 || obs_en[9] !== 1'b1) begin
            n_errors++;
            $display("FAIL pc_halt_en: got en9=%b en10=%b want 1 0", obs_en[9], obs_en[10]);
        end
        pc = 8'd3; mach_code = 9'h55;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1 || core_en !== 1'b0 || core_rst !== 1'b0 ||
            cycle_count !== 16'd11 || instr_count !== 16'd10) begin
            n_errors++;
            $display("FAIL done_hold: got done=%b en=%b rst=%b cc=%0d ic=%0d want 1 0 0 11 10",
                     done, core_en, core_rst, cycle_count, instr_count);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_halt();
        fill_default();
        prog_mc[0] = 9'h1A3; prog_mc[1] = 9'h000; prog_mc[2] = 9'h0F1;
        prog_mc[3] = 9'h000; prog_mc[4] = 9'h000;
        model_run();
        begin_run(1'b0);
        drive_program(-1);
        n_checks++;
        if (obs_cycles !== exp_cycles || instr_count !== 16'(exp_instr) ||
            cycle_count !== 16'(exp_cycles) || timeout !== exp_timeout) begin
            n_errors++;
            $display("FAIL zero_halt: got end=%0d cc=%0d ic=%0d to=%b want %0d %0d %0d %b",
                     obs_cycles, cycle_count, instr_count, timeout,
                     exp_cycles, exp_cycles, exp_instr, exp_timeout);
        end
        n_checks++;
        if (obs_en[1] !== 1'b1 || obs_en[3] !== 1'b1 || obs_en[4] !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_halt_en: got en1=%b en3=%b en4=%b want 1 1 0",
                     obs_en[1], obs_en[3], obs_en[4]);
        end
    endtask

    task automatic test_timeout();
        fill_default();
        for (int i = 0; i < 64; i++) prog_pc[i] = 8'(i % 4);
        model_run();
        begin_run(1'b0);
        drive_program(-1);
        n_checks++;
        if (obs_cycles !== exp_cycles || cycle_count !== 16'(exp_cycles) ||
            instr_count !== 16'(exp_instr) || timeout !== exp_timeout) begin
            n_errors++;
            $display("FAIL timeout: got end=%0d cc=%0d ic=%0d to=%b want %0d %0d %0d %b",
                     obs_cycles, cycle_count, instr_count, timeout,
                     exp_cycles, exp_cycles, exp_instr, exp_timeout);
        end
    endtask

    task automatic test_timeout_halt_tie();
        fill_default();
        for (int i = 0; i < 64; i++) prog_pc[i] = 8'(i % 4);
        prog_pc[T_MAX-1] = T_HALT_PC;
        model_run();
        begin_run(1'b0);
        drive_program(-1);
        n_checks++;
        if (obs_cycles !== exp_cycles || cycle_count !== 16'(exp_cycles) ||
            instr_count !== 16'(exp_instr) || timeout !== exp_timeout) begin
            n_errors++;
            $display("FAIL tie: got end=%0d cc=%0d ic=%0d to=%b want %0d %0d %0d %b",
                     obs_cycles, cycle_count, instr_count, timeout,
                     exp_cycles, exp_cycles, exp_instr, exp_timeout);
        end
    endtask

    task automatic test_start_ignored();
        fill_default();
        for (int i = 0; i < 10; i++) prog_pc[i] = 8'(i);
        prog_pc[10] = T_HALT_PC;
        model_run();
        begin_run(1'b1);
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (obs_cw[k] !== 1'b1 || obs_ca[k] !== 2'(k)) begin
                n_errors++;
                $display("FAIL start_in_clear%0d: got wen=%b addr=%0d want 1 %0d",
                         k, obs_cw[k], obs_ca[k], k);
            end
        end
        drive_program(3);
        n_checks++;
        if (obs_cycles !== exp_cycles || cycle_count !== 16'(exp_cycles) ||
            instr_count !== 16'(exp_instr)) begin
            n_errors++;
            $display("FAIL start_in_run: got end=%0d cc=%0d ic=%0d want %0d %0d %0d",
                     obs_cycles, cycle_count, instr_count, exp_cycles, exp_cycles, exp_instr);
        end
    endtask

    task automatic test_restart_from_done();
        fill_default();
        for (int i = 0; i < 64; i++) prog_pc[i] = 8'(i % 4);
        begin_run(1'b0);
        drive_program(-1);
        // Now in DONE with timeout set; restart must clear everything
        fill_default();
        prog_pc[2] = T_HALT_PC;
        begin_run(1'b0);
        n_checks++;
        if (obs_done0 !== 1'b0 || obs_to0 !== 1'b0 || obs_cc0 !== 16'd0 || obs_ic0 !== 16'd0) begin
            n_errors++;
            $display("FAIL restart: got done=%b to=%b cc=%0d ic=%0d want 0 0 0 0",
                     obs_done0, obs_to0, obs_cc0, obs_ic0);
        end
        n_checks++;
        if (obs_ca[0] !== 2'd0 || obs_ca[3] !== 2'd3 || obs_cw[3] !== 1'b1) begin
            n_errors++;
            $display("FAIL restart_clear: got a0=%0d a3=%0d wen3=%b want 0 3 1",
                     obs_ca[0], obs_ca[3], obs_cw[3]);
        end
        drive_program(-1);
    endtask

    task automatic test_random_runs();
        for (int r = 0; r < 12; r++) begin
            for (int i = 0; i < 64; i++) begin
                prog_pc[i] = ($urandom_range(0, 15) == 0) ? T_HALT_PC : 8'($urandom_range(0, 254));
                prog_mc[i] = ($urandom_range(0, 2) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
            end
            model_run();
            begin_run(1'b0);
            drive_program(-1);
            n_checks++;
            if (obs_cycles !== exp_cycles || cycle_count !== 16'(exp_cycles) ||
                instr_count !== 16'(exp_instr) || timeout !== exp_timeout) begin
                n_errors++;
                $display("FAIL random%0d: got end=%0d cc=%0d ic=%0d to=%b want %0d %0d %0d %b",
                         r, obs_cycles, cycle_count, instr_count, timeout,
                         exp_cycles, exp_cycles, exp_instr, exp_timeout);
            end
            for (int i = 0; i < exp_cycles; i++) begin
                n_checks++;
                if (obs_en[i] !== ((i < exp_cycles - 1) ? 1'b1 : exp_timeout)) begin
                    n_errors++;
                    $display("FAIL random%0d_en%0d: got %b want %b", r, i, obs_en[i],
                             (i < exp_cycles - 1) ? 1'b1 : exp_timeout);
                end
            end
        end
    endtask

    task automatic test_async_reset();
        fill_default();
        begin_run(1'b0);
        pc = 8'd1; mach_code = 9'h0C3;
        repeat (3) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (core_en !== 1'b0 || core_rst !== 1'b1 || done !== 1'b0 ||
            cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            n_errors++;
            $display("FAIL async_reset: got en=%b rst=%b done=%b cc=%0d ic=%0d want 0 1 0 0 0",
                     core_en, core_rst, done, cycle_count, instr_count);
        end
        @(negedge clk); reset = 1'b1;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (core_rst !== 1'b1 || core_en !== 1'b0 || clr_wen !== 1'b0) begin
                n_errors++;
                $display("FAIL stay_idle: got rst=%b en=%b wen=%b want 1 0 0",
                         core_rst, core_en, clr_wen);
            end
        end
        @(posedge clk); #1;
        prog_pc[6] = T_HALT_PC;
        model_run();
        begin_run(1'b0);
        drive_program(-1);
        n_checks++;
        if (obs_cycles !== exp_cycles || instr_count !== 16'(exp_instr)) begin
            n_errors++;
            $display("FAIL run_after_reset: got end=%0d ic=%0d want %0d %0d",
                     obs_cycles, instr_count, exp_cycles, exp_instr);
        end
    endtask

    initial begin
        test_reset();
        test_clear_sequence();
        test_pc_halt();
        test_zero_halt();
        test_timeout();
        test_timeout_halt_tie();
        test_start_ignored();
        test_restart_from_done();
        test_random_runs();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
